// File: rtl/tube_para_dma_if.sv
// Bus bundle between the parasite DMA engine and its environment (config port, ULA register 3, memory).
interface tube_para_dma_if #(
    parameter int ADDR_W = 16
);
    logic              CFG_WE;
    logic [1:0]        CFG_ADDR;
    logic [15:0]       CFG_WDATA;
    logic [15:0]       CFG_RDATA;
    logic              DRQ;
    logic              DACK;
    logic              PNRDS;
    logic              PNWDS;
    logic [7:0]        PDIN;
    logic [7:0]        PDOUT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_WDATA;
    logic              MEM_WE;
    logic              MEM_RE;
    logic [7:0]        MEM_RDATA;
    logic              IRQ;

    modport master (
        input  CFG_WE, CFG_ADDR, CFG_WDATA, DRQ, PDOUT, MEM_RDATA,
        output CFG_RDATA, DACK, PNRDS, PNWDS, PDIN, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, IRQ
    );

    modport slave (
        output CFG_WE, CFG_ADDR, CFG_WDATA, DRQ, PDOUT, MEM_RDATA,
        input  CFG_RDATA, DACK, PNRDS, PNWDS, PDIN, MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, IRQ
    );
endinterface

// File: rtl/tube_para_dma.sv
// Parasite-side DMA engine for tube_ula register 3: moves bytes between the ULA FIFO and
// parasite memory under DRQ/DACK, programmed through a 4-register port, IRQ on completion.
module tube_para_dma #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              HO2,
    input  logic              RST,
    tube_para_dma_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ULA_RD, S_MEM_WR, S_MEM_RD, S_MEM_CAP, S_ULA_WR
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_mem_addr;
    logic [CNT_W-1:0]  r_count, w_count_dec;
    logic              r_en, r_dir, r_ie, r_done, r_irq;
    logic [7:0]        r_data;
    logic              r_dack, r_pnrds, r_pnwds, r_mem_we, r_mem_re;
    logic              w_busy, w_byte_done, w_set_done, w_clr_en;
    logic              w_wr_addr, w_wr_count, w_wr_ctrl, w_wr_status;
    logic [15:0]       w_rdata;
    logic              w_unused_cfg;

    assign w_busy      = (r_state != S_IDLE);
    assign w_byte_done = (r_state == S_MEM_WR) || (r_state == S_ULA_WR);
    assign w_count_dec = (r_count == '0) ? '0 : r_count - CNT_W'(1);

    assign w_wr_addr   = bus.CFG_WE && (bus.CFG_ADDR == 2'd0) && !w_busy;
    assign w_wr_count  = bus.CFG_WE && (bus.CFG_ADDR == 2'd1) && !w_busy;
    assign w_wr_ctrl   = bus.CFG_WE && (bus.CFG_ADDR == 2'd2);
    assign w_wr_status = bus.CFG_WE && (bus.CFG_ADDR == 2'd3);
    assign w_unused_cfg = &{1'b0, bus.CFG_WDATA};

    always_comb begin
        w_next     = r_state;
        w_set_done = 1'b0;
        w_clr_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    if (r_count != '0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_set_done = 1'b1;
                        w_clr_en   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!r_en)
                    w_next = S_IDLE;
                else if (bus.DRQ)
                    w_next = r_dir ? S_MEM_RD : S_ULA_RD;
            end
            S_ULA_RD:  w_next = S_MEM_WR;
            S_MEM_RD:  w_next = S_MEM_CAP;
            S_MEM_CAP: w_next = S_ULA_WR;
            S_MEM_WR, S_ULA_WR: begin
                if (w_count_dec == '0) begin
                    w_next     = S_IDLE;
                    w_set_done = 1'b1;
                    w_clr_en   = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HO2) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge HO2) begin
        if (RST) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_en       <= 1'b0;
            r_dir      <= 1'b0;
            r_ie       <= 1'b0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
            r_data     <= '0;
            r_dack     <= 1'b1;
            r_pnrds    <= 1'b1;
            r_pnwds    <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            if (w_wr_addr)
                r_addr <= bus.CFG_WDATA[ADDR_W-1:0];
            else if (w_byte_done)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_wr_count)
                r_count <= bus.CFG_WDATA[CNT_W-1:0];
            else if (w_byte_done)
                r_count <= w_count_dec;

            if (w_wr_ctrl) begin
                r_en <= bus.CFG_WDATA[0];
                r_ie <= bus.CFG_WDATA[2];
                if (!w_busy)
                    r_dir <= bus.CFG_WDATA[1];
            end
            if (w_clr_en)
                r_en <= 1'b0;

            // Completion beats a simultaneous write-1-to-clear.
            if (w_set_done)
                r_done <= 1'b1;
            else if (w_wr_status && bus.CFG_WDATA[1])
                r_done <= 1'b0;

            r_irq <= r_done & r_ie;

            if (r_state == S_ULA_RD)
                r_data <= bus.PDOUT;
            else if (r_state == S_MEM_CAP)
                r_data <= bus.MEM_RDATA;

            // Strobes are decoded from the next state so they are registered and aligned with it.
            r_dack   <= !((w_next == S_ULA_RD) || (w_next == S_ULA_WR));
            r_pnrds  <= (w_next != S_ULA_RD);
            r_pnwds  <= (w_next != S_ULA_WR);
            r_mem_we <= (w_next == S_MEM_WR);
            r_mem_re <= (w_next == S_MEM_RD);
            if ((w_next == S_MEM_WR) || (w_next == S_MEM_RD))
                r_mem_addr <= r_addr;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.CFG_ADDR)
            2'd0:    w_rdata[ADDR_W-1:0] = r_addr;
            2'd1:    w_rdata[CNT_W-1:0]  = r_count;
            2'd2:    w_rdata[2:0]        = {r_ie, r_dir, r_en};
            default: w_rdata[1:0]        = {r_done, w_busy};
        endcase
    end

    assign bus.CFG_RDATA = w_rdata;
    assign bus.DACK      = r_dack;
    assign bus.PNRDS     = r_pnrds;
    assign bus.PNWDS     = r_pnwds;
    assign bus.PDIN      = r_data;
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_WDATA = r_data;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_RE    = r_mem_re;
    assign bus.IRQ       = r_irq;
endmodule

// File: tb/tb_tube_para_dma.sv
// Randomized bench for tube_para_dma: behavioural ULA and memory, expected transfers derived
// from start address, byte count and the supplied data.
module tb_tube_para_dma;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic HO2 = 1'b0;
    logic RST = 1'b1;

    tube_para_dma_if #(.ADDR_W(ADDR_W)) bus ();

    tube_para_dma #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .HO2 (HO2),
        .RST (RST),
        .bus (bus)
    );

    always #10 HO2 = ~HO2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [0:65535];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] xdata[$];
    int  n_dack_lo = 0, n_we = 0, n_re = 0, n_viol = 0;
    bit  drq_rand = 1'b0;
    logic drq_val = 1'b0;

    always @(posedge HO2) begin
        if (bus.MEM_RE) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
        if (bus.MEM_WE) mem[bus.MEM_ADDR] = bus.MEM_WDATA;
    end

    // ULA side: present queue head, consume on a read strobe, record bytes on a write strobe.
    always @(negedge HO2) begin
        if (!bus.PNRDS) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end else begin
            bus.PDOUT = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
        if (!bus.PNWDS) rx_q.push_back(bus.PDIN);
        if (!bus.DACK) n_dack_lo++;
        if (bus.MEM_WE) n_we++;
        if (bus.MEM_RE) n_re++;
        if (((bus.DACK == 1'b0) != ((bus.PNRDS == 1'b0) ^ (bus.PNWDS == 1'b0))) ||
            (!bus.PNRDS && !bus.PNWDS))
            n_viol++;
        bus.DRQ = drq_rand ? 1'($urandom % 2) : drq_val;
    end

    task automatic tick();
        @(negedge HO2);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        bus.CFG_WE    = 1'b1;
        bus.CFG_ADDR  = a;
        bus.CFG_WDATA = d;
        tick();
        bus.CFG_WE    = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [15:0] d);
        bus.CFG_ADDR = a;
        #1;
        d = bus.CFG_RDATA;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        logic [15:0] c, s;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            cfg_rd(2'd2, c);
            cfg_rd(2'd3, s);
            if (!c[0] && !s[0]) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic run_xfer(input bit dir, input logic [15:0] addr, input int cnt, input bit ie,
                            input bit rnd_drq, input int hold_lo, input bit poke);
        logic [15:0] r, a_end;
        logic [7:0]  sentinel;
        logic        irq0, irq1;
        bit          timed_out;
        if (xdata.size() != cnt) begin
            xdata.delete();
            for (int i = 0; i < cnt; i++) xdata.push_back(8'($urandom));
        end
        cfg_wr(2'd3, 16'h0002);
        cfg_wr(2'd0, addr);
        cfg_wr(2'd1, 16'(cnt));
        tick();
        tick();
        a_end = addr + 16'(cnt);
        sentinel = 8'($urandom);
        mem[a_end] = sentinel;
        for (int i = 0; i < cnt; i++) begin
            if (dir) mem[addr + 16'(i)] = xdata[i];
            else     tx_q.push_back(xdata[i]);
        end
        rx_q.delete();
        n_dack_lo = 0;
        n_we = 0;
        n_re = 0;
        drq_rand = rnd_drq;
        drq_val = (hold_lo == 0);
        cfg_wr(2'd2, {13'd0, ie, dir, 1'b1});
        if (hold_lo > 0) begin
            repeat (hold_lo) tick();
            chk("drq_low_no_dack", n_dack_lo, 0);
            chk("drq_low_no_re", n_re, 0);
            drq_val = 1'b1;
        end
        if (poke) begin
            tick();
            tick();
            cfg_wr(2'd0, ~addr);
            cfg_wr(2'd1, 16'h0007);
            cfg_wr(2'd2, {13'd0, ie, ~dir, 1'b1});
        end
        wait_idle(60 * cnt + 50, timed_out);
        irq0 = bus.IRQ;
        tick();
        irq1 = bus.IRQ;
        chk("xfer_timeout", timed_out, 0);
        if (dir) begin
            chk("rx_len", rx_q.size(), cnt);
            for (int i = 0; i < cnt && i < rx_q.size(); i++) chk("rx_byte", rx_q[i], xdata[i]);
            chk("re_count", n_re, cnt);
            chk("we_none", n_we, 0);
        end else begin
            for (int i = 0; i < cnt; i++) chk("mem_byte", mem[addr + 16'(i)], xdata[i]);
            chk("we_count", n_we, cnt);
        end
        chk("sentinel", mem[a_end], sentinel);
        cfg_rd(2'd0, r); chk("end_addr", r, a_end);
        cfg_rd(2'd1, r); chk("end_count", r, 0);
        cfg_rd(2'd2, r); chk("end_ctrl", r, {13'd0, ie, dir, 1'b0});
        cfg_rd(2'd3, r); chk("end_status", r, 16'h0002);
        chk("dack_cycles", n_dack_lo, cnt);
        chk("irq_at_done", irq0, 1'b0);
        chk("irq_after", irq1, ie);
        xdata.delete();
        drq_rand = 1'b0;
        drq_val = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  b0;
        bit          to, found;
        int          cnt;
        logic [15:0] addr;

        bus.CFG_WE    = 1'b0;
        bus.CFG_ADDR  = 2'd0;
        bus.CFG_WDATA = 16'h0000;
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_dack", bus.DACK, 1'b1);
        chk("rst_pnrds", bus.PNRDS, 1'b1);
        chk("rst_pnwds", bus.PNWDS, 1'b1);
        chk("rst_irq", bus.IRQ, 1'b0);
        chk("rst_pdin", bus.PDIN, 8'h00);
        chk("rst_mem_we", bus.MEM_WE, 1'b0);
        chk("rst_mem_re", bus.MEM_RE, 1'b0);
        chk("rst_mem_addr", bus.MEM_ADDR, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            cfg_rd(2'(a), r);
            chk("rst_rdata", r, 16'h0000);
        end
        RST = 1'b0;
        tick();

        // ULA -> memory, two bytes.
        xdata = '{8'hAA, 8'hAB};
        run_xfer(1'b0, 16'h1000, 2, 1'b1, 1'b0, 0, 1'b0);

        // Memory -> ULA with DRQ held off for five cycles.
        xdata = '{8'h55, 8'h56, 8'h57};
        run_xfer(1'b1, 16'h00FE, 3, 1'b1, 1'b0, 5, 1'b0);

        // Address wrap.
        run_xfer(1'b0, 16'hFFFF, 2, 1'b0, 1'b0, 0, 1'b0);

        // EN cleared during the first byte's ULA read.
        cfg_wr(2'd3, 16'h0002);
        cfg_wr(2'd0, 16'h2000);
        cfg_wr(2'd1, 16'd4);
        tick();
        tick();
        b0 = 8'($urandom);
        tx_q.delete();
        tx_q.push_back(b0);
        for (int i = 1; i < 4; i++) tx_q.push_back(8'($urandom));
        n_dack_lo = 0;
        drq_val = 1'b1;
        cfg_wr(2'd2, 16'h0005);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.PNRDS) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("enclr_saw_rd", found, 1'b1);
        cfg_wr(2'd2, 16'h0004);
        wait_idle(40, to);
        tick();
        tick();
        chk("enclr_timeout", to, 1'b0);
        cfg_rd(2'd1, r); chk("enclr_count", r, 16'd3);
        cfg_rd(2'd0, r); chk("enclr_addr", r, 16'h2001);
        cfg_rd(2'd3, r); chk("enclr_status", r, 16'h0000);
        cfg_rd(2'd2, r); chk("enclr_ctrl", r, 16'h0004);
        chk("enclr_irq", bus.IRQ, 1'b0);
        chk("enclr_mem", mem[16'h2000], b0);
        chk("enclr_dack", n_dack_lo, 1);
        tx_q.delete();
        drq_val = 1'b0;

        // EN with COUNT=0, DONE clear collides with DONE set.
        cfg_wr(2'd1, 16'd0);
        n_dack_lo = 0;
        cfg_wr(2'd2, 16'h0005);
        cfg_rd(2'd3, r); chk("zc_pre_status", r, 16'h0000);
        cfg_wr(2'd3, 16'h0002);
        cfg_rd(2'd3, r); chk("zc_done_set_wins", r, 16'h0002);
        cfg_rd(2'd2, r); chk("zc_ctrl", r, 16'h0004);
        chk("zc_irq_early", bus.IRQ, 1'b0);
        tick();
        chk("zc_irq", bus.IRQ, 1'b1);
        chk("zc_no_dack", n_dack_lo, 0);
        cfg_wr(2'd3, 16'h0002);
        cfg_rd(2'd3, r); chk("w1c_done", r, 16'h0000);

        // Randomized transfers, with busy-time register writes on longer ones.
        for (int t = 0; t < 14; t++) begin
            cnt = 1 + int'($urandom % 6);
            addr = ($urandom % 4 == 0) ? 16'hFFFF - 16'($urandom % 4) : 16'($urandom);
            run_xfer(1'($urandom % 2), addr, cnt, 1'($urandom % 2), 1'b1, 0, cnt >= 4);
        end

        // Reset during a ULA read strobe.
        cfg_wr(2'd0, 16'h3000);
        cfg_wr(2'd1, 16'd5);
        for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
        drq_val = 1'b1;
        cfg_wr(2'd2, 16'h0001);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.PNRDS) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_saw_rd", found, 1'b1);
        RST = 1'b1;
        tick();
        chk("abort_pnrds", bus.PNRDS, 1'b1);
        chk("abort_dack", bus.DACK, 1'b1);
        chk("abort_mem_we", bus.MEM_WE, 1'b0);
        cfg_rd(2'd3, r); chk("abort_status", r, 16'h0000);
        cfg_rd(2'd1, r); chk("abort_count", r, 16'h0000);
        cfg_rd(2'd2, r); chk("abort_ctrl", r, 16'h0000);
        RST = 1'b0;
        drq_val = 1'b0;
        tick();
        tx_q.delete();
        chk("abort_idle_pnrds", bus.PNRDS, 1'b1);

        chk("strobe_rules", n_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tube_para_dma.md
Name: tube_para_dma

Overview:
- Parasite-side DMA engine directly downstream of tube_ula register 3.
- Services the ULA DRQ line with DACK-qualified strobes. Moves bytes between the register 3 FIFO and parasite memory, so the parasite CPU is not involved per byte.
- Programmed through a small register port.
- Signals completion by an interrupt.

Parameters:
- ADDR_W, 16, parasite memory address width.
- CNT_W, 16, transfer count width.

Ports:
- HO2  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- CFG_WE  in  1  register write strobe.
- CFG_ADDR  in  2  register select: 0=ADDR, 1=COUNT, 2=CTRL, 3=STATUS.
- CFG_WDATA  in  16  register write data.
- CFG_RDATA  out  16  combinational readback of the selected register.
- DRQ  in  1  ULA DMA request, active-high.
- DACK  out  1  ULA DMA acknowledge, active-low.
- PNRDS  out  1  ULA read strobe, active-low.
- PNWDS  out  1  ULA write strobe, active-low.
- PDIN  out  8  data to ULA.
- PDOUT  in  8  data from ULA.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  8  memory write data.
- MEM_WE  out  1  memory write enable.
- MEM_RE  out  1  memory read enable.
- MEM_RDATA  in  8  memory read data, valid the cycle after MEM_RE.
- IRQ  out  1  completion interrupt, active-high.

Behaviour:
- Reset values:
  - DACK=1, PNRDS=1, PNWDS=1, PDIN=0.
  - MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0.
  - IRQ=0.
  - ADDR=0, COUNT=0, CTRL=0, DONE=0; state IDLE.
  - Reset mid-transfer aborts immediately. No strobe is extended past the reset edge.
- Register map:
  - CTRL bit0 EN, bit1 DIR (0 = ULA->memory, 1 = memory->ULA), bit2 IE.
  - STATUS bit0 BUSY (read-only, state != IDLE), bit1 DONE (write 1 to clear).
- Writes to ADDR, COUNT, or CTRL.DIR while BUSY are ignored. EN and IE remain writable while BUSY.
- States: IDLE, WAIT, ULA_RD, MEM_WR, MEM_RD, MEM_CAP, ULA_WR.
- IDLE:
  - EN=1 and COUNT!=0 -> WAIT.
  - EN=1 and COUNT=0 -> set DONE, clear EN, stay IDLE; no bus cycles issued.
- WAIT: DRQ is sampled only here.
  - EN=0 -> IDLE.
  - Else DRQ=1 -> ULA_RD if DIR=0, MEM_RD if DIR=1.
- DIR=0, ULA to memory:
  - ULA_RD: exactly one cycle. DACK=0 and PNRDS=0 as registered outputs. PDOUT is captured at the closing edge.
  - MEM_WR: one cycle. MEM_WE=1, MEM_ADDR=ADDR, MEM_WDATA=captured byte. ADDR+1 and COUNT-1 at the closing edge.
- DIR=1, memory to ULA:
  - MEM_RD: MEM_RE=1, MEM_ADDR=ADDR.
  - MEM_CAP: capture MEM_RDATA.
  - ULA_WR: one cycle. DACK=0, PNWDS=0, PDIN=captured byte. ADDR+1 and COUNT-1 at the closing edge.
- After MEM_WR or ULA_WR:
  - Decremented COUNT=0 -> set DONE, clear EN, go IDLE.
  - Else -> WAIT.
- Throughput: minimum 3 cycles per byte for DIR=0 and 4 cycles per byte for DIR=1. The gap cycle lets the ULA update DRQ before it is sampled again.
- ADDR wraps modulo 2^ADDR_W. COUNT never underflows.
- Clearing EN mid-byte: the current byte completes and the counters update. The engine then returns to IDLE from WAIT without setting DONE. ADDR and COUNT show the remaining transfer.
- Strobe rules:
  - DACK is low only when exactly one of PNRDS or PNWDS is low.
  - PNRDS and PNWDS are never low together.
- IRQ is registered: IRQ = DONE & IE, one cycle after either changes.
- A STATUS write-1-to-clear of DONE in the same cycle as DONE being set: set wins.

Test Plan:
- Reset with RST=1 for 3 cycles -> DACK, PNRDS, PNWDS=1, IRQ=0, CFG_RDATA=0 for all addresses.
- DIR=0, ADDR=0x1000, COUNT=2, IE=1, EN=1, ULA supplies 0xAA then 0xAB with DRQ high -> memory writes 0xAA@0x1000 and 0xAB@0x1001, ADDR=0x1002, COUNT=0, DONE=1, EN=0, IRQ=1 one cycle later.
- DIR=1, COUNT=3, memory holds 0x55, 0x56, 0x57 at 0x00FE, DRQ low for 5 cycles then high -> no strobes while DRQ low; PDIN sequence 0x55, 0x56, 0x57 with PNWDS low one cycle each; ADDR=0x0101.
- Wrap: ADDR=0xFFFF, COUNT=2 -> writes land at 0xFFFF then 0x0000.
- EN cleared during ULA_RD of byte 1 of 4 -> byte 1 completes, state IDLE, COUNT=3, DONE=0, IRQ=0.
- EN=1 with COUNT=0 -> DONE=1 next cycle, no DACK pulse. A STATUS write of 0x0002 in the same cycle DONE sets leaves DONE=1.
